// File: rtl/prod_term_pkg.sv
// prod_term_pkg: shared defaults, per-term configuration record and index-width helper
package prod_term_pkg;
  localparam int DEF_N_IN  = 7;
  localparam int DEF_N_OUT = 3;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_N_IN  = 32;
  typedef struct packed {
    logic [MAX_N_IN-1:0] mask;
    logic                inv;
  } cfg_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pte_hit_counter.sv
// pte_hit_counter: saturating event counter with synchronous clear
module pte_hit_counter import prod_term_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/prod_term_engine.sv
// prod_term_engine: configurable product-term evaluator with 2-stage valid/ready pipeline and hit counters
module prod_term_engine import prod_term_pkg::*; #(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT-1:0]        out_data,
  input  logic                    cfg_we,
  output logic                    cfg_ready,
  input  logic [idx_w(N_OUT)-1:0] cfg_idx,
  input  logic [N_IN-1:0]         cfg_mask,
  input  logic                    cfg_inv,
  output logic                    cfg_err,
  input  logic                    cnt_clr,
  output logic [N_OUT*CNT_W-1:0]  hit_cnt
);
  cfg_t                cfg [N_OUT];
  logic                s1_v, s2_v, s1_load, s2_load, cfg_take, in_fire;
  logic [N_OUT-1:0]    s1_and, and_now, inv_vec;
  logic [MAX_N_IN-1:0] din;
  assign din = MAX_N_IN'(in_data);
  // unused mask bits stay 0, so their ~mask is 1 and they drop out of the AND
  always_comb begin
    and_now = '0;
    inv_vec = '0;
    for (int k = 0; k < N_OUT; k++) begin
      and_now[k] = &(din | ~cfg[k].mask);
      inv_vec[k] = cfg[k].inv;
    end
  end
  assign s2_load   = !s2_v || out_ready;
  assign s1_load   = !s1_v || s2_load;
  assign cfg_ready = !rst && !s1_v && !s2_v;
  assign cfg_take  = cfg_we && cfg_ready;
  assign in_ready  = !rst && s1_load && !cfg_take;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_v;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s1_and   <= '0;
      out_data <= '0;
      cfg_err  <= 1'b0;
      for (int k = 0; k < N_OUT; k++) cfg[k] <= '0;
    end else begin
      if (s1_load) s1_v <= in_fire;
      if (in_fire) s1_and <= and_now;
      if (s2_load) s2_v <= s1_v;
      if (s2_load && s1_v) out_data <= s1_and ^ inv_vec;
      cfg_err <= cfg_take && int'(cfg_idx) >= N_OUT;
      for (int k = 0; k < N_OUT; k++)
        if (cfg_take && int'(cfg_idx) == k) cfg[k] <= '{mask: MAX_N_IN'(cfg_mask), inv: cfg_inv};
    end
  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    pte_hit_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .clr(cnt_clr),
      .inc(out_valid && out_ready && out_data[g]),
      .cnt(hit_cnt[g*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_prod_term_engine.sv
// tb_prod_term_engine: randomized self-checking bench against a behavioural product-term model
module tb_prod_term_engine;
  localparam int N_IN = 7, N_OUT = 3, CNT_W = 2, CMAX = 3;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 1, cfg_we = 0, cfg_inv = 0, cnt_clr = 0;
  logic in_ready, out_valid, cfg_ready, cfg_err;
  logic [N_IN-1:0] in_data = '0, cfg_mask = '0;
  logic [1:0] cfg_idx = '0;
  logic [N_OUT-1:0] out_data;
  logic [N_OUT*CNT_W-1:0] hit_cnt;
  int n_vec = 0, n_err = 0, err_pulses = 0;
  logic [N_IN-1:0] mask_m [N_OUT];
  logic inv_m [N_OUT];
  int cnt_m [N_OUT];
  logic [N_OUT-1:0] q [$];
  logic in_hs, out_hs, cfg_hs, have_exp, out_v_obs, cfg_rdy_obs;
  logic [N_OUT-1:0] out_obs, exp_out;

  always #5 clk = ~clk;

  prod_term_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
    .cfg_inv(cfg_inv), .cfg_err(cfg_err), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
  );

  function automatic logic [N_OUT-1:0] model(input logic [N_IN-1:0] d);
    logic [N_OUT-1:0] r;
    r = '0;
    for (int k = 0; k < N_OUT; k++) r[k] = ((d & mask_m[k]) == mask_m[k]) ^ inv_m[k];
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < N_OUT; k++) begin
      mask_m[k] = '0;
      inv_m[k] = 1'b0;
      cnt_m[k] = 0;
    end
  endtask

  // sample handshakes mid-cycle, advance the model, then step past the next rising edge
  task automatic tick();
    @(negedge clk);
    in_hs = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    out_v_obs = out_valid;
    cfg_rdy_obs = cfg_ready;
    cfg_hs = cfg_we && cfg_ready;
    out_obs = out_data;
    err_pulses += int'(cfg_err);
    have_exp = 1'b0;
    if (out_hs && q.size() > 0) begin
      exp_out = q.pop_front();
      have_exp = 1'b1;
    end
    for (int k = 0; k < N_OUT; k++)
      if (cnt_clr) cnt_m[k] = 0;
      else if (have_exp && exp_out[k] && cnt_m[k] < CMAX) cnt_m[k]++;
    if (in_hs) q.push_back(model(in_data));
    if (cfg_hs && cfg_idx < N_OUT) begin
      mask_m[cfg_idx] = cfg_mask;
      inv_m[cfg_idx] = cfg_inv;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [N_IN-1:0] m, input logic inv);
    int guard = 0;
    cfg_we = 1; cfg_idx = idx; cfg_mask = m; cfg_inv = inv;
    do begin tick(); guard++; end while (!cfg_hs && guard < 50);
    cfg_we = 0;
    n_vec++;
    if (!cfg_hs) begin n_err++; $display("FAIL cfg_write_timeout: cfg_ready=%b want 1", cfg_rdy_obs); end
  endtask

  task automatic send(input logic [N_IN-1:0] v);
    int guard = 0;
    in_valid = 1; in_data = v;
    do begin tick(); guard++; end while (!in_hs && guard < 50);
    in_valid = 0;
    n_vec++;
    if (!in_hs) begin n_err++; $display("FAIL send_timeout: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_vec += 6;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data: got %b want 000", out_data); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rst_cfg_ready: got %b want 0", cfg_ready); end
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end
    if (hit_cnt !== '0) begin n_err++; $display("FAIL rst_hit_cnt: got %h want 0", hit_cnt); end
    @(negedge clk); rst = 0; model_reset(); #1;
    n_vec += 2;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rel_cfg_ready: got %b want 1", cfg_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_truth_table();
    logic [N_IN-1:0] tv [2];
    logic [N_OUT-1:0] te [2];
    tv[0] = 7'h13; te[0] = 3'b111;
    tv[1] = 7'h7F; te[1] = 3'b001;
    out_ready = 1;
    cfg_write(0, 7'b0010011, 0);
    cfg_write(1, 7'b0011010, 1);
    cfg_write(2, 7'b1111100, 1);
    for (int i = 0; i < 2; i++) begin
      send(tv[i]);
      tick();
      n_vec++;
      if (out_hs !== 1'b0) begin n_err++; $display("FAIL tt_early_%0d: out_valid=%b want 0", i, out_v_obs); end
      tick();
      n_vec++;
      if (!out_hs || out_obs !== te[i]) begin
        n_err++; $display("FAIL tt_out_%0d: valid=%b data=%b want valid=1 data=%b", i, out_hs, out_obs, te[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    logic prev_stall = 0;
    logic [N_OUT-1:0] prev_data = '0;
    int sent = 0, got = 0, extra = 0;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    in_data = N_IN'($urandom);
    for (int c = 0; c < 200 && got < 8; c++) begin
      out_ready = pat[c % 4];
      in_valid = sent < 8;
      tick();
      if (prev_stall) begin
        n_vec++;
        if (!out_v_obs || out_obs !== prev_data) begin
          n_err++; $display("FAIL bp_stable: valid=%b data=%b want valid=1 data=%b", out_v_obs, out_obs, prev_data);
        end
      end
      if (in_hs) begin sent++; in_data = N_IN'($urandom); end
      if (out_hs) begin
        got++; n_vec++;
        if (!have_exp || out_obs !== exp_out) begin
          n_err++; $display("FAIL bp_data: got %b want %b (expected present=%b)", out_obs, exp_out, have_exp);
        end
      end
      prev_stall = out_v_obs && !out_ready;
      prev_data = out_obs;
    end
    in_valid = 0; out_ready = 1;
    repeat (4) begin tick(); if (out_hs) extra++; end
    n_vec++;
    if (got != 8 || extra != 0 || q.size() != 0) begin
      n_err++; $display("FAIL bp_count: delivered %0d extra %0d pending %0d want 8/0/0", got, extra, q.size());
    end
  endtask

  task automatic test_cfg_gate();
    out_ready = 0;
    send(N_IN'($urandom));
    cfg_we = 1; cfg_idx = 1; cfg_mask = 7'b0000001; cfg_inv = 1;
    repeat (3) begin
      tick();
      n_vec++;
      if (cfg_rdy_obs !== 1'b0) begin n_err++; $display("FAIL gate_busy: cfg_ready=%b want 0", cfg_rdy_obs); end
    end
    out_ready = 1;
    for (int c = 0; c < 10 && !cfg_hs; c++) begin
      tick();
      if (out_hs) begin
        n_vec++;
        if (!have_exp || out_obs !== exp_out) begin n_err++; $display("FAIL gate_drain: got %b want %b", out_obs, exp_out); end
      end
    end
    cfg_we = 0;
    n_vec++;
    if (!cfg_hs) begin n_err++; $display("FAIL gate_accept: cfg write not taken after drain"); end
    send(7'h01);
    for (int c = 0; c < 10 && !out_hs; c++) tick();
    n_vec++;
    if (!out_hs || out_obs[1] !== 1'b0 || out_obs !== exp_out) begin
      n_err++; $display("FAIL gate_newmask: got %b want %b", out_obs, exp_out);
    end
  endtask

  task automatic test_cfg_priority();
    out_ready = 1;
    cfg_we = 1; cfg_idx = 0; cfg_mask = N_IN'($urandom) & N_IN'($urandom); cfg_inv = 1'($urandom);
    in_valid = 1; in_data = N_IN'($urandom);
    #1;
    n_vec += 2;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL prio_in_ready: got %b want 0", in_ready); end
    if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL prio_cfg_ready: got %b want 1", cfg_ready); end
    tick();
    cfg_we = 0;
    n_vec++;
    if (!cfg_hs || in_hs) begin n_err++; $display("FAIL prio_take: cfg=%b in=%b want cfg=1 in=0", cfg_hs, in_hs); end
    tick();
    in_valid = 0;
    n_vec++;
    if (!in_hs) begin n_err++; $display("FAIL prio_stall: in handshake=%b want 1", in_hs); end
    for (int c = 0; c < 10 && !out_hs; c++) tick();
    n_vec++;
    if (!out_hs || out_obs !== exp_out) begin n_err++; $display("FAIL prio_out: got %b want %b", out_obs, exp_out); end
  endtask

  task automatic test_bad_index();
    logic [N_IN-1:0] v;
    logic [N_OUT-1:0] first;
    v = N_IN'($urandom);
    out_ready = 1;
    send(v);
    for (int c = 0; c < 10 && !out_hs; c++) tick();
    first = out_obs;
    n_vec++;
    if (!out_hs || out_obs !== exp_out) begin n_err++; $display("FAIL bad_pre: got %b want %b", out_obs, exp_out); end
    err_pulses = 0;
    cfg_write(3, ~mask_m[0], ~inv_m[0]);
    repeat (3) tick();
    n_vec++;
    if (err_pulses != 1) begin n_err++; $display("FAIL bad_err_pulse: cfg_err high %0d cycles want 1", err_pulses); end
    send(v);
    for (int c = 0; c < 10 && !out_hs; c++) tick();
    n_vec++;
    if (!out_hs || out_obs !== first) begin n_err++; $display("FAIL bad_unchanged: got %b want %b", out_obs, first); end
  endtask

  task automatic test_counters();
    out_ready = 1;
    cfg_write(0, '0, 0);
    cnt_clr = 1; tick(); cnt_clr = 0;
    n_vec++;
    if (hit_cnt[CNT_W-1:0] !== '0) begin n_err++; $display("FAIL cnt_clear: got %0d want 0", hit_cnt[CNT_W-1:0]); end
    for (int i = 0; i < 5; i++) send(N_IN'($urandom));
    repeat (4) tick();
    n_vec++;
    if (hit_cnt[CNT_W-1:0] !== 2'd3) begin n_err++; $display("FAIL cnt_sat: got %0d want 3", hit_cnt[CNT_W-1:0]); end
    for (int k = 0; k < N_OUT; k++) begin
      n_vec++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== CNT_W'(cnt_m[k])) begin
        n_err++; $display("FAIL cnt_model_%0d: got %0d want %0d", k, hit_cnt[k*CNT_W +: CNT_W], cnt_m[k]);
      end
    end
    out_ready = 0;
    send(N_IN'($urandom));
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    out_ready = 1; cnt_clr = 1;
    tick();
    cnt_clr = 0;
    n_vec += 2;
    if (!out_hs) begin n_err++; $display("FAIL cnt_clr_hit: output handshake=%b want 1", out_hs); end
    if (hit_cnt[CNT_W-1:0] !== '0) begin n_err++; $display("FAIL cnt_clr_prio: got %0d want 0", hit_cnt[CNT_W-1:0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_data = N_IN'($urandom);
      out_ready = $urandom_range(0, 9) < 7;
      cfg_we = $urandom_range(0, 19) == 0;
      cfg_idx = 2'($urandom_range(0, 3));
      cfg_mask = N_IN'($urandom) & N_IN'($urandom);
      cfg_inv = 1'($urandom);
      cnt_clr = $urandom_range(0, 29) == 0;
      tick();
      if (out_hs) begin
        n_vec++;
        if (!have_exp || out_obs !== exp_out) begin n_err++; $display("FAIL rnd_data: got %b want %b (present=%b)", out_obs, exp_out, have_exp); end
      end
    end
    in_valid = 0; cfg_we = 0; cnt_clr = 0; out_ready = 1;
    repeat (4) begin
      tick();
      if (out_hs) begin
        n_vec++;
        if (!have_exp || out_obs !== exp_out) begin n_err++; $display("FAIL rnd_drain: got %b want %b", out_obs, exp_out); end
      end
    end
    n_vec++;
    if (q.size() != 0) begin n_err++; $display("FAIL rnd_pending: %0d results never delivered, want 0", q.size()); end
    for (int k = 0; k < N_OUT; k++) begin
      n_vec++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== CNT_W'(cnt_m[k])) begin
        n_err++; $display("FAIL rnd_cnt_%0d: got %0d want %0d", k, hit_cnt[k*CNT_W +: CNT_W], cnt_m[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1;
    in_data = N_IN'($urandom); tick();
    in_data = N_IN'($urandom); tick();
    in_valid = 0;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre: out_valid=%b want 1", out_valid); end
    #2 rst = 1;
    #1;
    model_reset();
    n_vec += 5;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin n_err++; $display("FAIL arst_data: got %b want 000", out_data); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL arst_in_ready: got %b want 0", in_ready); end
    if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL arst_cfg_ready: got %b want 0", cfg_ready); end
    if (hit_cnt !== '0) begin n_err++; $display("FAIL arst_cnt: got %h want 0", hit_cnt); end
    @(posedge clk); #3 rst = 0;
    #1;
    n_vec += 2;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_rel_in: got %b want 1", in_ready); end
    if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL arst_rel_cfg: got %b want 1", cfg_ready); end
    out_ready = 1; in_valid = 1; in_data = N_IN'($urandom);
    tick();
    in_valid = 0;
    n_vec++;
    if (!in_hs) begin n_err++; $display("FAIL arst_accept: in handshake=%b want 1", in_hs); end
    tick();
    n_vec++;
    if (out_hs !== 1'b0) begin n_err++; $display("FAIL arst_stale: old vector emitted %b", out_obs); end
    tick();
    n_vec++;
    if (!out_hs || out_obs !== 3'b111 || !have_exp) begin
      n_err++; $display("FAIL arst_first: valid=%b data=%b want valid=1 data=111", out_hs, out_obs);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_truth_table();
    test_backpressure();
    test_cfg_gate();
    test_cfg_priority();
    test_bad_index();
    test_counters();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
